// File: rtl/fifo_uart_serializer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_ser_pkg
// Shared types and constants for the FIFO-to-UART serializer.
//   ser_state_t    : drain/serialize FSM states
//   FRAME_BITS     : start + payload + stop bits for the default payload width
//   frame_bits()   : frame length in bits for an arbitrary payload width
//   cpb_legal()    : legality check for the clocks-per-bit parameter
// ---------------------------------------------------------------------------
package fifo_ser_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      WAIT  = 3'd2,
      START = 3'd3,
      DATA  = 3'd4,
      STOP  = 3'd5
   } ser_state_t;

   localparam int DATA_WIDTH_DEFAULT = 8;
   localparam int FRAME_BITS         = DATA_WIDTH_DEFAULT + 2;

   // One start bit and one stop bit wrap the payload.
   function automatic int frame_bits(input int data_width);
      return data_width + 2;
   endfunction

   // A bit period shorter than one clock cannot be represented.
   function automatic bit cpb_legal(input int clks_per_bit);
      return (clks_per_bit >= 1);
   endfunction

endpackage

// File: rtl/fifo_uart_serializer_bit_timer.sv
// ---------------------------------------------------------------------------
// ser_bit_timer
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit period; wraps on its own so consecutive bits need no re-arm.
//   clk      : system clock
//   rst      : synchronous active-high reset
//   clr      : restart the count at 0 on the next cycle (frame start)
//   bit_end  : high during the last clock of the current bit period
// ---------------------------------------------------------------------------
module ser_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end
);

   localparam int            CW   = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;
   logic          bit_end_r;

   // Next count: restart on clear, wrap after the last cycle of a bit.
   always_comb begin
      cnt_next_s = cnt_r;
      if (clr) begin
         cnt_next_s = {CW{1'b0}};
      end else if (cnt_r == LAST) begin
         cnt_next_s = {CW{1'b0}};
      end else begin
         cnt_next_s = cnt_r + CW'(1);
      end
   end

   // Count register; bit_end is registered from the next count so it is
   // aligned with the cycle in which the counter holds LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= {CW{1'b0}};
         bit_end_r <= 1'b0;
      end else begin
         cnt_r     <= cnt_next_s;
         bit_end_r <= (cnt_next_s == LAST);
      end
   end

   assign bit_end = bit_end_r;

endmodule

// File: rtl/fifo_uart_serializer.sv
// ---------------------------------------------------------------------------
// fifo_uart_serializer
// Drains bytes from a synchronous FIFO and sends each as a UART frame:
// start bit (0), DATA_WIDTH data bits LSB first, stop bit (1). tx idles high.
// A read is only issued from IDLE with the FIFO non-empty, so this side can
// never underrun the FIFO.
//   clk          : system clock
//   rst          : synchronous active-high reset
//   en           : drain enable, looked at only in IDLE
//   fifo_empty   : FIFO empty flag
//   fifo_re      : one-cycle FIFO read pulse per byte
//   fifo_rdata   : FIFO read data, valid the cycle after fifo_re
//   tx           : serial output
//   busy         : high from the read cycle through the end of the stop bit
//   frame_done   : one-cycle pulse after each completed frame
//   frame_count  : completed frames since reset, wraps
// ---------------------------------------------------------------------------
module fifo_uart_serializer
   import fifo_ser_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  fifo_empty,
   output logic                  fifo_re,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CNT_WIDTH-1:0]  frame_count
);

   if (!cpb_legal(CLKS_PER_BIT)) begin : g_cpb_illegal
      $error("fifo_uart_serializer: CLKS_PER_BIT must be 1 or more");
   end

   localparam int            IW       = $clog2(DATA_WIDTH + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

   ser_state_t            state_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic [DATA_WIDTH-1:0] shift_next_s;
   logic [IW-1:0]         bit_idx_r;
   logic                  tx_r;
   logic                  fifo_re_r;
   logic                  busy_r;
   logic                  frame_done_r;
   logic [CNT_WIDTH-1:0]  frame_count_r;
   logic                  timer_clr_s;
   logic                  bit_end_s;

   // Restart the bit timer on the WAIT->START edge so START gets a full period.
   always_comb begin
      timer_clr_s = 1'b0;
      if (state_r == WAIT) begin
         timer_clr_s = 1'b1;
      end else begin
         timer_clr_s = 1'b0;
      end
   end

   // Payload after dropping the bit just sent; its LSB is the next tx value.
   always_comb begin
      shift_next_s = shift_r >> 1;
   end

   ser_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr_s),
      .bit_end (bit_end_s)
   );

   // Drain/serialize FSM with registered outputs. tx is loaded on the edge
   // that enters each bit so it changes together with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         shift_r       <= {DATA_WIDTH{1'b0}};
         bit_idx_r     <= {IW{1'b0}};
         tx_r          <= 1'b1;
         fifo_re_r     <= 1'b0;
         busy_r        <= 1'b0;
         frame_done_r  <= 1'b0;
         frame_count_r <= {CNT_WIDTH{1'b0}};
      end else begin
         fifo_re_r    <= 1'b0;
         frame_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (en && !fifo_empty) begin
                  state_r   <= RD;
                  fifo_re_r <= 1'b1;
                  busy_r    <= 1'b1;
               end
            end
            RD: begin
               state_r <= WAIT;
            end
            WAIT: begin
               shift_r   <= fifo_rdata;
               bit_idx_r <= {IW{1'b0}};
               tx_r      <= 1'b0;
               state_r   <= START;
            end
            START: begin
               if (bit_end_s) begin
                  tx_r    <= shift_r[0];
                  state_r <= DATA;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  if (bit_idx_r == LAST_IDX) begin
                     tx_r    <= 1'b1;
                     state_r <= STOP;
                  end else begin
                     shift_r   <= shift_next_s;
                     tx_r      <= shift_next_s[0];
                     bit_idx_r <= bit_idx_r + IW'(1);
                  end
               end
            end
            STOP: begin
               if (bit_end_s) begin
                  state_r       <= IDLE;
                  busy_r        <= 1'b0;
                  frame_done_r  <= 1'b1;
                  frame_count_r <= frame_count_r + CNT_WIDTH'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               tx_r    <= 1'b1;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_re     = fifo_re_r;
   assign tx          = tx_r;
   assign busy        = busy_r;
   assign frame_done  = frame_done_r;
   assign frame_count = frame_count_r;

endmodule

// File: tb/tb_fifo_uart_serializer.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_serializer
// Two serializers share one clock: dut0 with 4 clocks per bit, dut1 with 1.
// Each is fed by a behavioural 8-deep FIFO. Bytes are queued on the
// scoreboard when written; a monitor pops one per observed start bit and
// checks every tx cycle of the frame against it.
// ---------------------------------------------------------------------------
module tb_fifo_uart_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_n = 0;

   logic rst0, rst1, en0, en1, fifo_rst;
   logic re0, re1, tx0, tx1, busy0, busy1, done0, done1;
   logic [15:0] fc0, fc1;
   logic empty0, empty1;

   // behavioural FIFOs
   logic       wr_en   [2];
   logic [7:0] wr_data [2];
   logic [7:0] mem     [2][8];
   logic [7:0] rdata   [2];
   int         wp [2], rp [2], fcnt [2];
   logic       under [2], over [2];

   // scoreboard and monitor state
   logic [7:0] sb [2][$];
   int         starts [2][$];
   int         re_cyc [2][$];
   logic       mon_act [2];
   int         mon_cyc [2];
   logic [7:0] mon_byte [2];
   int         frames [2], re_cnt [2], done_cnt [2];

   assign empty0 = (fcnt[0] == 0);
   assign empty1 = (fcnt[1] == 0);

   fifo_uart_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .CNT_WIDTH(16)) dut0 (
      .clk(clk), .rst(rst0), .en(en0), .fifo_empty(empty0), .fifo_re(re0),
      .fifo_rdata(rdata[0]), .tx(tx0), .busy(busy0), .frame_done(done0),
      .frame_count(fc0));

   fifo_uart_serializer #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .CNT_WIDTH(16)) dut1 (
      .clk(clk), .rst(rst1), .en(en1), .fifo_empty(empty1), .fifo_re(re1),
      .fifo_rdata(rdata[1]), .tx(tx1), .busy(busy1), .frame_done(done1),
      .frame_count(fc1));

   always @(posedge clk) cyc_n <= cyc_n + 1;

   // FIFO models: registered read data, sticky underrun/overrun flags
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         automatic int   c  = fcnt[k];
         automatic logic re = (k == 0) ? re0 : re1;
         if (fifo_rst) begin
            wp[k] <= 0; rp[k] <= 0; fcnt[k] <= 0; under[k] <= 1'b0; over[k] <= 1'b0;
            rdata[k] <= 8'h00;
         end else begin
            if (re === 1'b1) begin
               if (c == 0) under[k] <= 1'b1;
               else begin
                  rdata[k] <= mem[k][rp[k]];
                  rp[k] <= (rp[k] + 1) % 8;
                  c = c - 1;
               end
            end
            if (wr_en[k]) begin
               if (c == 8) over[k] <= 1'b1;
               else begin
                  mem[k][wp[k]] <= wr_data[k];
                  wp[k] <= (wp[k] + 1) % 8;
                  c = c + 1;
               end
            end
            fcnt[k] <= c;
         end
      end
   end

   function automatic logic fbit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      else if (b >= 9) return 1'b1;
      else return d[b-1];
   endfunction

   // Frame monitors: pop the expected byte at each start bit, check every cycle
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         automatic logic t  = (k == 0) ? tx0 : tx1;
         automatic logic b  = (k == 0) ? busy0 : busy1;
         automatic logic r  = (k == 0) ? re0 : re1;
         automatic logic dn = (k == 0) ? done0 : done1;
         automatic int   c  = (k == 0) ? 4 : 1;
         if (mon_act[k] && b !== 1'b1) begin
            mon_act[k] = 1'b0;
         end else if (!mon_act[k] && t === 1'b0) begin
            mon_act[k] = 1'b1;
            mon_cyc[k] = 0;
            starts[k].push_back(cyc_n);
            n_cmp++;
            if (sb[k].size() == 0) begin
               n_err++;
               $display("FAIL mon%0d_start: frame started, expected no frame", k);
               mon_byte[k] = 8'h00;
            end else begin
               mon_byte[k] = sb[k].pop_front();
            end
         end
         if (mon_act[k]) begin
            n_cmp++;
            if (t !== fbit(mon_byte[k], mon_cyc[k] / c)) begin
               n_err++;
               $display("FAIL mon%0d_bit: byte %h cycle %0d tx=%b expected %b",
                        k, mon_byte[k], mon_cyc[k], t, fbit(mon_byte[k], mon_cyc[k] / c));
            end
            mon_cyc[k]++;
            if (mon_cyc[k] == 10 * c) begin
               mon_act[k] = 1'b0;
               frames[k]++;
            end
         end
         if (r === 1'b1) begin
            re_cnt[k]++;
            re_cyc[k].push_back(cyc_n);
         end
         if (dn === 1'b1) done_cnt[k]++;
      end
   end

   task automatic clear_stats(input int k);
      frames[k] = 0; re_cnt[k] = 0; done_cnt[k] = 0;
      starts[k].delete(); re_cyc[k].delete();
   endtask

   task automatic fifo_write(input int k, input logic [7:0] d);
      @(negedge clk);
      wr_en[k] = 1'b1; wr_data[k] = d;
      sb[k].push_back(d);
      @(negedge clk);
      wr_en[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (done_cnt[k] >= target) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_re0(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (re0 === 1'b1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      fifo_write(0, 8'hA5);
      en0 = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++;
         if (tx0 !== 1'b1 || re0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || fc0 !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_outputs: tx=%b re=%b busy=%b done=%b cnt=%h expected 1 0 0 0 0000",
                     tx0, re0, busy0, done0, fc0);
         end
      end
      en0 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (fcnt[0] !== 1 || re_cnt[0] !== 0) begin
         n_err++;
         $display("FAIL reset_no_pop: fifo count %0d pops %0d expected 1 0", fcnt[0], re_cnt[0]);
      end
   endtask

   task automatic test_single();
      bit ok;
      clear_stats(0);
      @(negedge clk); en0 = 1'b1;
      wait_done(0, 1, 200, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL single_timeout: frame_done count %0d expected 1", done_cnt[0]); end
      repeat (5) @(negedge clk);
      en0 = 1'b0;
      n_cmp++;
      if (re_cnt[0] !== 1) begin n_err++; $display("FAIL single_re: pulses %0d expected 1", re_cnt[0]); end
      n_cmp++;
      if (done_cnt[0] !== 1 || fc0 !== 16'd1) begin
         n_err++; $display("FAIL single_done: done %0d count %0d expected 1 1", done_cnt[0], fc0);
      end
      n_cmp++;
      if (frames[0] !== 1) begin n_err++; $display("FAIL single_frames: seen %0d expected 1", frames[0]); end
      n_cmp++;
      if (starts[0].size() < 1 || re_cyc[0].size() < 1 || starts[0][0] - re_cyc[0][0] !== 2) begin
         n_err++; $display("FAIL single_latency: start-read gap wrong, expected 2 cycles");
      end
      n_cmp++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
         n_err++; $display("FAIL single_idle: tx=%b busy=%b expected 1 0", tx0, busy0);
      end
   endtask

   task automatic test_burst();
      bit ok;
      bit hi_ok;
      @(negedge clk); rst0 = 1'b1;
      @(negedge clk); rst0 = 1'b0;
      clear_stats(0);
      for (int i = 0; i < 8; i++) fifo_write(0, 8'($urandom_range(0, 255)));
      @(negedge clk); en0 = 1'b1;
      wait_done(0, 8, 600, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL burst_timeout: frame_done count %0d expected 8", done_cnt[0]); end
      hi_ok = 1'b1;
      repeat (20) begin @(negedge clk); if (tx0 !== 1'b1) hi_ok = 1'b0; end
      en0 = 1'b0;
      n_cmp++;
      if (!hi_ok) begin n_err++; $display("FAIL burst_tx_idle: tx left high state, expected 1"); end
      n_cmp++;
      if (re_cnt[0] !== 8) begin n_err++; $display("FAIL burst_re: pulses %0d expected 8", re_cnt[0]); end
      for (int i = 1; i < 8 && i < re_cyc[0].size(); i++) begin
         n_cmp++;
         if (re_cyc[0][i] - re_cyc[0][i-1] !== 43) begin
            n_err++; $display("FAIL burst_spacing: pop %0d gap %0d expected 43", i, re_cyc[0][i] - re_cyc[0][i-1]);
         end
      end
      n_cmp++;
      if (fcnt[0] !== 0 || under[0] !== 1'b0 || over[0] !== 1'b0) begin
         n_err++; $display("FAIL burst_fifo: count %0d under %b over %b expected 0 0 0", fcnt[0], under[0], over[0]);
      end
      n_cmp++;
      if (fc0 !== 16'd8 || frames[0] !== 8 || sb[0].size() !== 0) begin
         n_err++; $display("FAIL burst_count: count %0d frames %0d left %0d expected 8 8 0", fc0, frames[0], sb[0].size());
      end
   endtask

   task automatic test_enable_gating();
      bit ok;
      bit quiet;
      clear_stats(0);
      fifo_write(0, 8'h3C);
      fifo_write(0, 8'hC3);
      quiet = 1'b1;
      repeat (100) begin @(negedge clk); if (re0 !== 1'b0 || tx0 !== 1'b1) quiet = 1'b0; end
      n_cmp++;
      if (!quiet) begin n_err++; $display("FAIL gate_idle: activity with en=0, expected none"); end
      en0 = 1'b1;
      wait_re0(20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL gate_start: no fifo_re within 20 cycles, expected one"); end
      repeat (19) @(negedge clk);
      en0 = 1'b0;                       // inside data bit 3
      wait_done(0, 1, 100, ok);
      repeat (60) @(negedge clk);
      n_cmp++;
      if (re_cnt[0] !== 1 || done_cnt[0] !== 1 || frames[0] !== 1) begin
         n_err++; $display("FAIL gate_one_frame: re %0d done %0d frames %0d expected 1 1 1", re_cnt[0], done_cnt[0], frames[0]);
      end
      n_cmp++;
      if (fcnt[0] !== 1 || fc0 !== 16'd9) begin
         n_err++; $display("FAIL gate_state: fifo %0d count %0d expected 1 9", fcnt[0], fc0);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      bit quiet;
      clear_stats(0);
      fifo_write(0, 8'h81);
      en0 = 1'b1;
      wait_re0(20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL rstmid_start: no fifo_re within 20 cycles, expected one"); end
      repeat (27) @(negedge clk);
      rst0 = 1'b1; en0 = 1'b0;          // inside data bit 5
      @(negedge clk);
      n_cmp++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || fc0 !== 16'd0 || done0 !== 1'b0) begin
         n_err++; $display("FAIL rstmid_outputs: tx=%b busy=%b cnt=%h done=%b expected 1 0 0000 0", tx0, busy0, fc0, done0);
      end
      rst0 = 1'b0;
      quiet = 1'b1;
      repeat (60) begin @(negedge clk); if (tx0 !== 1'b1) quiet = 1'b0; end
      n_cmp++;
      if (!quiet || done_cnt[0] !== 0 || frames[0] !== 0) begin
         n_err++; $display("FAIL rstmid_abort: tx_high %b done %0d frames %0d expected 1 0 0", quiet, done_cnt[0], frames[0]);
      end
      n_cmp++;
      if (re_cnt[0] !== 1 || fcnt[0] !== 1) begin
         n_err++; $display("FAIL rstmid_pops: pops %0d fifo %0d expected 1 1", re_cnt[0], fcnt[0]);
      end
   endtask

   task automatic test_cpb1_back_to_back();
      bit ok;
      clear_stats(1);
      fifo_write(1, 8'h00);
      fifo_write(1, 8'hFF);
      fifo_write(1, 8'h3C);
      @(negedge clk); en1 = 1'b1;
      wait_done(1, 3, 200, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL cpb1_timeout: frame_done count %0d expected 3", done_cnt[1]); end
      repeat (5) @(negedge clk);
      en1 = 1'b0;
      n_cmp++;
      if (fc1 !== 16'd3 || frames[1] !== 3 || re_cnt[1] !== 3) begin
         n_err++; $display("FAIL cpb1_count: count %0d frames %0d re %0d expected 3 3 3", fc1, frames[1], re_cnt[1]);
      end
      for (int i = 1; i < 3 && i < starts[1].size(); i++) begin
         n_cmp++;
         if (starts[1][i] - starts[1][i-1] !== 13) begin
            n_err++; $display("FAIL cpb1_period: frame %0d period %0d expected 13", i, starts[1][i] - starts[1][i-1]);
         end
      end
      n_cmp++;
      if (sb[1].size() !== 0) begin n_err++; $display("FAIL cpb1_sb: %0d bytes unsent expected 0", sb[1].size()); end
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0; fifo_rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wr_en[k] = 1'b0; wr_data[k] = 8'h00; mon_act[k] = 1'b0; mon_cyc[k] = 0;
         mon_byte[k] = 8'h00; frames[k] = 0; re_cnt[k] = 0; done_cnt[k] = 0;
      end
      repeat (2) @(negedge clk);
      fifo_rst = 1'b0;
      test_reset();
      test_single();
      test_burst();
      test_enable_gating();
      test_reset_mid_frame();
      test_cpb1_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_uart_serializer.md
Name: fifo_uart_serializer

Overview:
Downstream drain stage for sync_8x8_fifo. It pops bytes from the FIFO read port and shifts each one out as a UART-style serial frame: one start bit (0), DATA_WIDTH data bits LSB first, and one stop bit (1). The tx line idles high. The block never issues a read while the FIFO is empty, so FIFO underrun cannot occur from this side.

Parameters:
DATA_WIDTH, 8, width of FIFO data word and serial payload
CLKS_PER_BIT, 4, clk cycles per serial bit; legal range is 1 or more, elaboration error otherwise
CNT_WIDTH, 16, width of frame counter

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
en  input  1  drain enable; sampled only in IDLE
fifo_empty  input  1  FIFO empty flag
fifo_re  output  1  FIFO read enable; one-cycle pulse per byte
fifo_rdata  input  DATA_WIDTH  FIFO r_data; valid the cycle after fifo_re is sampled
tx  output  1  serial output; idles high
busy  output  1  high from RD until end of STOP
frame_done  output  1  one-cycle pulse after each completed frame
frame_count  output  CNT_WIDTH  completed frames since reset; wraps

Behaviour:
- Reset (rst=1 at posedge) puts the block in state IDLE with tx=1, fifo_re=0, busy=0, frame_done=0, frame_count=0. Shift register and counters clear.
- Reset mid-frame aborts the frame. From the next cycle tx=1, and no frame_done or count increment is produced.
- All outputs are registered. fifo_re is decoded from the state register (RD) and has no combinational path from en or fifo_empty.
- State IDLE: if en=1 and fifo_empty=0 at a posedge, go to RD. Otherwise stay in IDLE.
- State RD: fifo_re=1 and busy=1 for exactly one cycle. Always go to WAIT next.
- State WAIT: fifo_rdata is valid in this cycle. At the posedge, load it into the shift register, clear the bit-period counter and go to START.
- State START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- State DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the bit index. After bit DATA_WIDTH-1, go to STOP.
- State STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- On the STOP-to-IDLE posedge: frame_done=1 for the following single cycle, and frame_count increments (modulo 2^CNT_WIDTH, so 0xFFFF wraps to 0x0000).
- Latency: the IDLE-detect posedge is followed by RD, then WAIT, then the tx falling edge at the start of START. tx falls 2 cycles after the detecting posedge.
- Frame length: (DATA_WIDTH+2)*CLKS_PER_BIT cycles of tx activity.
- Back-to-back frames: a minimum gap of 3 tx-high cycles (IDLE, RD, WAIT) separates consecutive start bits. Frame period is therefore (DATA_WIDTH+2)*CLKS_PER_BIT+3 cycles.
- en=0 mid-frame: the current frame completes normally. No further fifo_re is issued until en=1 is seen in IDLE.
- fifo_empty is ignored outside IDLE. The byte is already committed at RD.
- The bit-period counter is $clog2(CLKS_PER_BIT+1) bits wide. CLKS_PER_BIT=1 gives one cycle per bit.

Decomposition:
- Package fifo_ser_pkg holds:
  - state enum ser_state_t {IDLE, RD, WAIT, START, DATA, STOP}
  - localparam FRAME_BITS = DATA_WIDTH+2
  - the parameter legality check
- One sub-module, ser_bit_timer: counts 0..CLKS_PER_BIT-1 and outputs a bit_end pulse on the last cycle. It is cleared by the FSM on entry to START. The FSM, shift register and frame counter stay in the top level.

Test Plan:
1. Reset: assert rst for 2 cycles with en=1 and the FIFO holding data. Required: tx=1, fifo_re=0, busy=0, frame_done=0, frame_count=0, and no FIFO pop.
2. Single byte (CLKS_PER_BIT=4): write 8'hA5 to the FIFO, then set en=1.
   - fifo_re high for exactly 1 cycle.
   - tx, in 4-cycle bits: 0, 1,0,1,0,0,1,0,1, then 1. That is 40 cycles total.
   - frame_done pulses once and frame_count=1.
3. Burst of 8 with the real sync_8x8_fifo: fill 8 $random bytes, then en=1.
   - 8 fifo_re pulses spaced 43 cycles apart.
   - The deserialized bytes match the write order.
   - FIFO empty after the 8th pop; underrun and overrun stay 0.
   - frame_count=8, then tx stays high.
4. Enable gating:
   - en=0 with the FIFO non-empty: no fifo_re and tx=1 for 100 cycles.
   - Drop en during bit 3 of a frame: the frame completes with a correct stop bit and no further pop.
5. Reset mid-frame: assert rst during data bit 5.
   - The next cycle has tx=1, busy=0 and frame_count=0.
   - No frame_done is produced.
   - The FIFO read pointer advances only for the one byte already popped.
6. CLKS_PER_BIT=1 variant: send 3 bytes 8'h00, 8'hFF, 8'h3C back-to-back. Required: each frame is 10 cycles, the gaps are 3 cycles, the bit patterns are correct, and frame_count=3.
